timer_intr_ctrl: RTL and testbench

//  Machine timer and interrupt-request source that sits directly upstream of CSR_RegFile.

---
 rtl/timer_intr_ctrl.sv | 137 +++++++++++++
 tb/tb_timer_intr_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_intr_ctrl.sv
// Machine timer (mtime/mtimecmp) and timer-interrupt request source.
// Feeds mip.MTIP and an interrupt request to the pipeline; the pipeline
// acknowledges the trap with intr_ack and signals handler exit with mret.
module timer_intr_ctrl #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_wr,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        mstatus_mie,
  input  logic        mie_mtie,
  input  logic        intr_ack,
  input  logic        mret,
  output logic        mtip,
  output logic        intr_req
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    MTIME_LO = 2'd0,
    MTIME_HI = 2'd1,
    CMP_LO   = 2'd2,
    CMP_HI   = 2'd3
  } reg_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    REQ,
    SVC
  } state_t;

  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic [PW-1:0] presc;
  logic          presc_wrap;
  reg_sel_t      sel;
  logic          en;
  state_t        state;
  state_t        state_next;

  // Every access is a full word; the two low address bits carry no meaning.
  assign sel        = reg_sel_t'(bus_addr[3:2]);
  assign presc_wrap = (presc == PRESC_LAST);
  assign en         = mstatus_mie & mie_mtie;

  // Combinational read-back of the addressed register.
  always_comb begin
    bus_rdata = '0;
    unique case (sel)
      MTIME_LO: bus_rdata = mtime[31:0];
      MTIME_HI: bus_rdata = mtime[63:32];
      CMP_LO:   bus_rdata = mtimecmp[31:0];
      CMP_HI:   bus_rdata = mtimecmp[63:32];
    endcase
  end

  // Prescaler and mtime; a software write to mtime replaces this cycle's
  // increment and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= '0;
      presc <= '0;
    end else if (bus_wr && sel == MTIME_LO) begin
      mtime[31:0] <= bus_wdata;
      presc       <= '0;
    end else if (bus_wr && sel == MTIME_HI) begin
      mtime[63:32] <= bus_wdata;
      presc        <= '0;
    end else if (presc_wrap) begin
      mtime <= mtime + 64'd1;
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // mtimecmp write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp <= '1;
    end else if (bus_wr && sel == CMP_LO) begin
      mtimecmp[31:0] <= bus_wdata;
    end else if (bus_wr && sel == CMP_HI) begin
      mtimecmp[63:32] <= bus_wdata;
    end
  end

  // Pending flag from the current (pre-write) register values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtip <= 1'b0;
    end else begin
      mtip <= (mtime >= mtimecmp);
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request FSM next state; ack wins in REQ, only mret leaves SVC.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (mtip && en)       state_next = REQ;
        else if (mtip && !en) state_next = PEND;
      end
      PEND: begin
        if (!mtip)   state_next = IDLE;
        else if (en) state_next = REQ;
      end
      REQ: begin
        if (intr_ack)   state_next = SVC;
        else if (!mtip) state_next = IDLE;
        else if (!en)   state_next = PEND;
      end
      SVC: begin
        if (mret) state_next = mtip ? PEND : IDLE;
      end
    endcase
  end

  assign intr_req = (state == REQ);

endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Bench for timer_intr_ctrl: two instances (PRESCALE 1 and 4) share the
// stimulus; a per-instance behavioural model predicts every output.
module tb_timer_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_wr = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [31:0] bus_wdata = '0;
  logic        mstatus_mie = 1'b0;
  logic        mie_mtie = 1'b0;
  logic        intr_ack = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] rdata0, rdata1;
  logic        mtip0, mtip1, req0, req1;

  int unsigned total = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  timer_intr_ctrl #(.PRESCALE(1)) dut0 (
    .clk(clk), .reset(reset), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(rdata0), .mstatus_mie(mstatus_mie),
    .mie_mtie(mie_mtie), .intr_ack(intr_ack), .mret(mret),
    .mtip(mtip0), .intr_req(req0)
  );

  timer_intr_ctrl #(.PRESCALE(4)) dut1 (
    .clk(clk), .reset(reset), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(rdata1), .mstatus_mie(mstatus_mie),
    .mie_mtie(mie_mtie), .intr_ack(intr_ack), .mret(mret),
    .mtip(mtip1), .intr_req(req1)
  );

  // Behavioural model. The request side is described by two facts only:
  // "a handler is running" and "a request is being shown"; outside a
  // handler a request is shown exactly when the timer is pending and enabled.
  int unsigned pre [2] = '{1, 4};
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  int unsigned m_cnt  [2];
  bit          m_mtip [2];
  bit          m_req  [2];
  bit          m_svc  [2];

  task automatic model_step(input int k);
    bit          nm;
    bit          enb;
    logic [1:0]  w;
    nm  = 1'b0;
    enb = mstatus_mie && mie_mtie;
    w   = bus_addr[3:2];
    if (reset) begin
      m_time[k] = 64'd0;
      m_cmp[k]  = {64{1'b1}};
      m_cnt[k]  = 0;
      m_mtip[k] = 1'b0;
      m_req[k]  = 1'b0;
      m_svc[k]  = 1'b0;
    end else begin
      nm = (m_time[k] >= m_cmp[k]);
      if (m_svc[k]) begin
        if (mret) begin
          m_svc[k] = 1'b0;
          m_req[k] = 1'b0;
        end
      end else if (m_req[k] && intr_ack) begin
        m_svc[k] = 1'b1;
        m_req[k] = 1'b0;
      end else begin
        m_req[k] = m_mtip[k] && enb;
      end
      m_mtip[k] = nm;
      if (bus_wr && w == 2'd0) begin
        m_time[k] = {m_time[k][63:32], bus_wdata};
        m_cnt[k]  = 0;
      end else if (bus_wr && w == 2'd1) begin
        m_time[k] = {bus_wdata, m_time[k][31:0]};
        m_cnt[k]  = 0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == pre[k]) begin
          m_cnt[k]  = 0;
          m_time[k] = m_time[k] + 64'd1;
        end
      end
      if (bus_wr && w == 2'd2) m_cmp[k] = {m_cmp[k][63:32], bus_wdata};
      if (bus_wr && w == 2'd3) m_cmp[k] = {bus_wdata, m_cmp[k][31:0]};
    end
  endtask

  function automatic logic [31:0] model_read(input int k);
    case (bus_addr[3:2])
      2'd0:    return m_time[k][31:0];
      2'd1:    return m_time[k][63:32];
      2'd2:    return m_cmp[k][31:0];
      default: return m_cmp[k][63:32];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdata_p1", {32'd0, rdata0}, {32'd0, model_read(0)});
    chk("rdata_p4", {32'd0, rdata1}, {32'd0, model_read(1)});
    chk("mtip_p1", {63'd0, mtip0}, {63'd0, m_mtip[0]});
    chk("mtip_p4", {63'd0, mtip1}, {63'd0, m_mtip[1]});
    chk("req_p1", {63'd0, req0}, {63'd0, m_req[0]});
    chk("req_p4", {63'd0, req1}, {63'd0, m_req[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_wr    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    tick();
    bus_wr = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a);
    bus_addr = a;
    #1;
    check_all();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_mtip", {63'd0, mtip0}, 64'd0);
    chk("reset_req", {63'd0, req0}, 64'd0);
    chk("reset_rd_lo", {32'd0, rdata0}, 64'd0);
    peek(4'hC);
    chk("reset_rd_cmphi", {32'd0, rdata0}, 64'h0000_0000_FFFF_FFFF);

    // T1: count after reset release
    reset = 1'b0;
    bus_addr = 4'h0;
    for (int i = 0; i < 5; i++) tick();
    chk("t1_mtime", {32'd0, rdata0}, 64'd5);
    peek(4'hC);
    chk("t1_cmphi", {32'd0, rdata0}, 64'h0000_0000_FFFF_FFFF);

    // T2: basic request
    mstatus_mie = 1'b1;
    mie_mtie    = 1'b1;
    wr(4'hC, 32'd0);
    wr(4'h8, 32'd20);
    bus_addr = 4'h0;
    for (int i = 0; i < 60 && !req0; i++) tick();
    chk("t2_req_seen", {63'd0, req0}, 64'd1);
    chk("t2_mtime_at_req", {32'd0, rdata0}, 64'd22);
    for (int i = 0; i < 3; i++) tick();
    chk("t2_req_hold", {63'd0, req0}, 64'd1);
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    chk("t2_req_after_ack", {63'd0, req0}, 64'd0);
    chk("t2_mtip_after_ack", {63'd0, mtip0}, 64'd1);

    // T4: service exit with timer still pending, then with it cleared
    tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("t4_pend", {63'd0, req0}, 64'd0);
    tick();
    chk("t4_rereq", {63'd0, req0}, 64'd1);
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    wr(4'hC, 32'd1);
    tick();
    chk("t4_mtip_clear", {63'd0, mtip0}, 64'd0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_idle_req", {63'd0, req0}, 64'd0);

    // T3: enable gating
    mie_mtie = 1'b0;
    wr(4'hC, 32'd0);
    wr(4'h8, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_gated_req", {63'd0, req0}, 64'd0);
    chk("t3_gated_mtip", {63'd0, mtip0}, 64'd1);
    mie_mtie = 1'b1;
    tick();
    chk("t3_enable_req", {63'd0, req0}, 64'd1);
    mstatus_mie = 1'b0;
    tick();
    chk("t3_withdraw", {63'd0, req0}, 64'd0);
    wr(4'h8, 32'hFFFF_FFFF);
    wr(4'hC, 32'hFFFF_FFFF);
    mstatus_mie = 1'b1;
    tick();
    tick();

    // T5: carry and wrap
    wr(4'h0, 32'hFFFF_FFFF);
    wr(4'h4, 32'h0);
    tick();
    peek(4'h4);
    chk("t5_carry_hi", {32'd0, rdata0}, 64'd1);
    peek(4'h0);
    chk("t5_carry_lo", {32'd0, rdata0}, 64'd0);
    wr(4'h4, 32'hFFFF_FFFF);
    wr(4'h0, 32'hFFFF_FFFF);
    tick();
    chk("t5_wrap_lo", {32'd0, rdata0}, 64'd0);
    peek(4'h4);
    chk("t5_wrap_hi", {32'd0, rdata0}, 64'd0);
    wr(4'h0, 32'h0000_1234);
    chk("t5_write_exact", {32'd0, rdata0}, 64'h1234);
    tick();
    chk("t5_after_write", {32'd0, rdata0}, 64'h1235);

    // T6: reset in the middle of a request
    wr(4'hC, 32'd0);
    wr(4'h8, 32'd0);
    for (int i = 0; i < 20 && !req0; i++) tick();
    chk("t6_req_seen", {63'd0, req0}, 64'd1);
    reset = 1'b1;
    intr_ack = 1'b1;
    tick();
    reset = 1'b0;
    intr_ack = 1'b0;
    chk("t6_req_reset", {63'd0, req0}, 64'd0);
    chk("t6_mtip_reset", {63'd0, mtip0}, 64'd0);
    peek(4'hC);
    chk("t6_cmp_reset", {32'd0, rdata0}, 64'h0000_0000_FFFF_FFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_recur", {63'd0, req0}, 64'd0);

    // PRESCALE=4 instance advances once every 4 cycles
    wr(4'h0, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("p4_rate", {32'd0, rdata1}, 64'd2);
    chk("p1_rate", {32'd0, rdata0}, 64'd8);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  w;
      logic [31:0] base;
      w = 2'($urandom_range(0, 3));
      mstatus_mie = ($urandom_range(0, 7) != 0);
      mie_mtie    = ($urandom_range(0, 7) != 0);
      intr_ack    = ($urandom_range(0, 3) == 0);
      mret        = ($urandom_range(0, 5) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      bus_wr      = ($urandom_range(0, 11) == 0);
      bus_addr    = {w, 2'($urandom_range(0, 3))};
      base        = m_time[0][31:0];
      case (w)
        2'd0:    bus_wdata = 32'($urandom_range(0, 40));
        2'd1:    bus_wdata = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
        2'd2:    bus_wdata = base + 32'($urandom_range(0, 30));
        default: bus_wdata = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : m_time[0][63:32];
      endcase
      tick();
    end
    reset    = 1'b0;
    bus_wr   = 1'b0;
    intr_ack = 1'b0;
    mret     = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
